// File: rtl/ioblock_cfg_pkg.sv
// Shared types and constants for the IO-block configuration controller:
// TSMUX encodings, per-IOB entry layout, FSM states and reset values.
package ioblock_cfg_pkg;

    localparam logic [1:0] TS_OFF   = 2'b00;
    localparam logic [1:0] TS_CTRL  = 2'b01;
    localparam logic [1:0] TS_DRIVE = 2'b10;  // 2'b11 also drives

    typedef struct packed {
        logic [1:0] tsmux;
        logic       dorreg;
    } iob_cfg_t;

    typedef enum logic {
        ST_IDLE,
        ST_QUIESCE
    } state_e;

    localparam iob_cfg_t IOB_CFG_RST = '{tsmux: TS_OFF, dorreg: 1'b0};

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ioblock_cfg_bank.sv
// Shadow register file: one range-checked write port with error pulse,
// one registered read port, and the whole bank exposed flat for commit.
module ioblock_cfg_bank
    import ioblock_cfg_pkg::*;
#(
    parameter int NUM_IOB = 40,
    parameter int ADDR_W  = addr_w(NUM_IOB)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  iob_cfg_t             wr_data_i,
    output logic                 wr_err_o,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output iob_cfg_t             rd_data_o,
    output logic [2*NUM_IOB-1:0] ts_flat_o,
    output logic [NUM_IOB-1:0]   dr_flat_o
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_IOB);

    iob_cfg_t bank_q [NUM_IOB];
    iob_cfg_t rd_q;
    logic     err_q;
    logic     wr_in_range;
    logic     rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr_i} < LIMIT);
    assign rd_in_range = ({1'b0, rd_addr_i} < LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the bank is plain flops and must read back defined values right after reset, so every entry is reset.
            for (int i = 0; i < NUM_IOB; i++) begin
                bank_q[i] <= IOB_CFG_RST;
            end
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_en_i && wr_in_range) begin
                bank_q[wr_addr_i] <= wr_data_i;
            end
            err_q <= wr_en_i && !wr_in_range;
            rd_q  <= rd_in_range ? bank_q[rd_addr_i] : '0;
        end
    end

    for (genvar g = 0; g < NUM_IOB; g++) begin : g_flat
        assign ts_flat_o[2*g +: 2] = bank_q[g].tsmux;
        assign dr_flat_o[g]        = bank_q[g].dorreg;
    end

    assign wr_err_o  = err_q;
    assign rd_data_o = rd_q;

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// IO-block configuration controller: shadow bank plus a commit FSM that
// holds every pin high-Z for SAFE_CYCLES, then loads all settings on one edge.
module ioblock_cfg_ctrl
    import ioblock_cfg_pkg::*;
#(
    parameter  int NUM_IOB     = 40,
    parameter  int SAFE_CYCLES = 2,
    localparam int ADDR_W      = addr_w(NUM_IOB)
) (
    input  logic                 IOCLK,
    input  logic                 RST,
    input  logic                 WR_VALID,
    output logic                 WR_READY,
    input  logic [ADDR_W-1:0]    WR_ADDR,
    input  logic [1:0]           WR_TSMUX,
    input  logic                 WR_DORREG,
    output logic                 WR_ERR,
    input  logic                 COMMIT,
    output logic                 BUSY,
    output logic                 DONE,
    input  logic [ADDR_W-1:0]    RD_ADDR,
    output logic [1:0]           RD_TSMUX,
    output logic                 RD_DORREG,
    output logic [2*NUM_IOB-1:0] TSMUX_BUS,
    output logic [NUM_IOB-1:0]   DORREG_BUS
);

    localparam logic [7:0] SAFE_CNT = 8'(SAFE_CYCLES);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   done_q, done_d;
    logic                   wr_ready_q;
    logic [2*NUM_IOB-1:0]   ts_bus_q, ts_bus_d;
    logic [NUM_IOB-1:0]     dr_bus_q, dr_bus_d;
    logic [2*NUM_IOB-1:0]   sh_ts;
    logic [NUM_IOB-1:0]     sh_dr;
    logic                   wr_fire;
    iob_cfg_t               wr_data;
    iob_cfg_t               rd_data;

    assign wr_fire = WR_VALID && wr_ready_q;
    assign wr_data = '{tsmux: WR_TSMUX, dorreg: WR_DORREG};

    ioblock_cfg_bank #(
        .NUM_IOB (NUM_IOB),
        .ADDR_W  (ADDR_W)
    ) u_bank (
        .clk_i     (IOCLK),
        .rst_i     (RST),
        .wr_en_i   (wr_fire),
        .wr_addr_i (WR_ADDR),
        .wr_data_i (wr_data),
        .wr_err_o  (WR_ERR),
        .rd_addr_i (RD_ADDR),
        .rd_data_o (rd_data),
        .ts_flat_o (sh_ts),
        .dr_flat_o (sh_dr)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        ts_bus_d = ts_bus_q;
        dr_bus_d = dr_bus_q;
        unique case (state_q)
            ST_IDLE: begin
                if (COMMIT || pend_q) begin
                    state_d  = ST_QUIESCE;
                    cnt_d    = SAFE_CNT;
                    pend_d   = 1'b0;
                    ts_bus_d = '0;
                end
            end
            ST_QUIESCE: begin
                if (COMMIT) begin
                    pend_d = 1'b1;
                end
                // All pins were already high-Z; the new settings land together here.
                if (cnt_q == 8'd1) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    ts_bus_d = sh_ts;
                    dr_bus_d = sh_dr;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            ts_bus_q   <= '0;
            dr_bus_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            wr_ready_q <= (state_d == ST_IDLE);
            ts_bus_q   <= ts_bus_d;
            dr_bus_q   <= dr_bus_d;
        end
    end

    assign WR_READY   = wr_ready_q;
    assign BUSY       = (state_q == ST_QUIESCE);
    assign DONE       = done_q;
    assign TSMUX_BUS  = ts_bus_q;
    assign DORREG_BUS = dr_bus_q;
    assign RD_TSMUX   = rd_data.tsmux;
    assign RD_DORREG  = rd_data.dorreg;

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// Directed bench for ioblock_cfg_ctrl (NUM_IOB=40, SAFE_CYCLES=2):
// reset, commit timing, same-cycle write, range error, pending commit, reset abort.
module tb_ioblock_cfg_ctrl;

    localparam int SAFE = 2;

    logic        IOCLK = 1'b0;
    logic        RST;
    logic        WR_VALID;
    logic        WR_READY;
    logic [5:0]  WR_ADDR;
    logic [1:0]  WR_TSMUX;
    logic        WR_DORREG;
    logic        WR_ERR;
    logic        COMMIT;
    logic        BUSY;
    logic        DONE;
    logic [5:0]  RD_ADDR;
    logic [1:0]  RD_TSMUX;
    logic        RD_DORREG;
    logic [79:0] TSMUX_BUS;
    logic [39:0] DORREG_BUS;

    int total = 0;
    int bad   = 0;

    logic [1:0] m_ts [40];
    logic       m_dr [40];
    logic [7:0] busy_v;
    logic [7:0] done_v;
    int         seen;

    ioblock_cfg_ctrl dut (
        .IOCLK      (IOCLK),
        .RST        (RST),
        .WR_VALID   (WR_VALID),
        .WR_READY   (WR_READY),
        .WR_ADDR    (WR_ADDR),
        .WR_TSMUX   (WR_TSMUX),
        .WR_DORREG  (WR_DORREG),
        .WR_ERR     (WR_ERR),
        .COMMIT     (COMMIT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .RD_ADDR    (RD_ADDR),
        .RD_TSMUX   (RD_TSMUX),
        .RD_DORREG  (RD_DORREG),
        .TSMUX_BUS  (TSMUX_BUS),
        .DORREG_BUS (DORREG_BUS)
    );

    always #5 IOCLK = ~IOCLK;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge IOCLK);
        #1;
    endtask

    // Runs the quiesce window after a sampled COMMIT and checks the DONE cycle.
    task automatic quiesce_checks(input logic [79:0] dr_prev);
        for (int k = 1; k <= SAFE; k++) begin
            step();
            COMMIT   = 1'b0;
            WR_VALID = 1'b0;
            chk("q_busy",  BUSY,       80'd1);
            chk("q_ts",    TSMUX_BUS,  80'd0);
            chk("q_dr",    DORREG_BUS, dr_prev);
            chk("q_ready", WR_READY,   80'd0);
            chk("q_done",  DONE,       80'd0);
        end
        step();
        chk("done_pulse", DONE,     80'd1);
        chk("done_busy",  BUSY,     80'd0);
        chk("done_ready", WR_READY, 80'd1);
    endtask

    initial begin
        for (int i = 0; i < 40; i++) begin
            m_ts[i] = 2'b00;
            m_dr[i] = 1'b0;
        end
        RST = 1'b1; WR_VALID = 1'b0; WR_ADDR = '0; WR_TSMUX = '0; WR_DORREG = 1'b0;
        COMMIT = 1'b0; RD_ADDR = '0;

        // Reset state
        step();
        step();
        chk("rst_ready", WR_READY,   80'd0);
        chk("rst_busy",  BUSY,       80'd0);
        chk("rst_done",  DONE,       80'd0);
        chk("rst_err",   WR_ERR,     80'd0);
        chk("rst_ts",    TSMUX_BUS,  80'd0);
        chk("rst_dr",    DORREG_BUS, 80'd0);
        chk("rst_rd",    {RD_TSMUX, RD_DORREG}, 80'd0);
        RST = 1'b0;
        step();
        chk("idle_ready", WR_READY,  80'd1);
        chk("idle_busy",  BUSY,      80'd0);
        chk("idle_ts",    TSMUX_BUS, 80'd0);

        // Write IOB 5 = {10, 1}, read it back, commit
        WR_VALID = 1'b1; WR_ADDR = 6'd5; WR_TSMUX = 2'b10; WR_DORREG = 1'b1;
        step();
        m_ts[5] = 2'b10; m_dr[5] = 1'b1;
        WR_VALID = 1'b0; RD_ADDR = 6'd5;
        chk("w5_err", WR_ERR, 80'd0);
        step();
        chk("rd5_ts", RD_TSMUX,  80'd2);
        chk("rd5_dr", RD_DORREG, 80'd1);
        COMMIT = 1'b1;
        quiesce_checks(80'd0);
        chk("c1_ts", TSMUX_BUS,  80'h800);
        chk("c1_dr", DORREG_BUS, 80'h20);
        step();
        chk("c1_done_off", DONE,      80'd0);
        chk("c1_ts_hold",  TSMUX_BUS, 80'h800);

        // Write IOB 3 = {01, 0} in the same cycle as COMMIT
        WR_VALID = 1'b1; WR_ADDR = 6'd3; WR_TSMUX = 2'b01; WR_DORREG = 1'b0;
        COMMIT = 1'b1;
        m_ts[3] = 2'b01;
        quiesce_checks(80'h20);
        chk("c2_ts", TSMUX_BUS,  80'h840);
        chk("c2_dr", DORREG_BUS, 80'h20);

        // Out-of-range write to address 40
        WR_VALID = 1'b1; WR_ADDR = 6'd40; WR_TSMUX = 2'b11; WR_DORREG = 1'b1;
        step();
        WR_VALID = 1'b0;
        chk("err_pulse", WR_ERR, 80'd1);
        step();
        chk("err_clear", WR_ERR, 80'd0);
        for (int i = 0; i < 40; i++) begin
            RD_ADDR = 6'(i);
            step();
            chk($sformatf("rd_ts[%0d]", i), RD_TSMUX,  80'(m_ts[i]));
            chk($sformatf("rd_dr[%0d]", i), RD_DORREG, 80'(m_dr[i]));
        end
        RD_ADDR = 6'd40;
        step();
        chk("rd_oor40", {RD_TSMUX, RD_DORREG}, 80'd0);
        RD_ADDR = 6'd63;
        step();
        chk("rd_oor63", {RD_TSMUX, RD_DORREG}, 80'd0);

        // COMMIT at cycle 0, repeated at 1 and 2 (busy); write IOB 9 in the DONE cycle
        COMMIT = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            busy_v[i-1] = BUSY;
            done_v[i-1] = DONE;
            COMMIT    = (i <= 2);
            WR_VALID  = (i == 3);
            WR_ADDR   = 6'd9;
            WR_TSMUX  = 2'b10;
            WR_DORREG = 1'b1;
        end
        m_ts[9] = 2'b10; m_dr[9] = 1'b1;
        chk("pend_busy", busy_v, 80'b0001_1011);
        chk("pend_done", done_v, 80'b0010_0100);
        chk("pend_ts",   TSMUX_BUS,  80'h80840);
        chk("pend_dr",   DORREG_BUS, 80'h220);

        // Reset in the middle of QUIESCE with a pending commit
        RD_ADDR = 6'd5;
        COMMIT  = 1'b1;
        step();
        step();
        chk("abort_busy_pre", BUSY, 80'd1);
        chk("abort_rd_pre",   RD_TSMUX, 80'd2);
        RST = 1'b1; COMMIT = 1'b0;
        step();
        chk("abort_busy",  BUSY,       80'd0);
        chk("abort_done",  DONE,       80'd0);
        chk("abort_ready", WR_READY,   80'd0);
        chk("abort_err",   WR_ERR,     80'd0);
        chk("abort_ts",    TSMUX_BUS,  80'd0);
        chk("abort_dr",    DORREG_BUS, 80'd0);
        chk("abort_rd",    {RD_TSMUX, RD_DORREG}, 80'd0);
        RST  = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (BUSY || DONE) seen++;
        end
        chk("abort_no_seq", 80'(seen), 80'd0);
        chk("abort_shadow", {RD_TSMUX, RD_DORREG}, 80'd0);
        chk("abort_ready2", WR_READY, 80'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
